// File: rtl/efuse_ctrl_if.sv
// Fuse macro port bundle: the controller drives address and strobes, the macro returns read data.
interface efuse_ctrl_if;
    logic [6:0] fuse_addr;
    logic       fuse_rd;
    logic       fuse_pgm;
    logic       fuse_q;

    modport master (output fuse_addr, output fuse_rd, output fuse_pgm, input fuse_q);
    modport slave  (input fuse_addr, input fuse_rd, input fuse_pgm, output fuse_q);
endinterface

// File: rtl/efuse_ctrl.sv
// eFuse controller: loads all 128 fuse bits into a shadow register after reset, then serves single-bit reads/programs.
// Define EFUSE_PGM_EN to build the program path; without it fuse_pgm is tied low and program requests are dropped.
module efuse_ctrl #(
    parameter int RD_CYC  = 4,
    parameter int PGM_CYC = 200
) (
    input  logic         clk,
    input  logic         rst,
    efuse_ctrl_if.master bus,
    input  logic         cfg_en,
    input  logic         efuse_mode,
    input  logic [6:0]   efuse_bit_addr,
    input  logic         op_req,
    output logic [127:0] efuse_data,
    output logic         efuse_done,
    output logic [7:0]   efuse_status,
    output logic         op_busy
);

    localparam int CNT_MAX = (PGM_CYC > RD_CYC) ? PGM_CYC : RD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
`ifdef EFUSE_PGM_EN
    localparam logic [CNT_W-1:0] PGM_LAST = CNT_W'(PGM_CYC - 1);
`endif

    typedef enum logic [2:0] {
        LD_SET, LD_RD, LD_CAP, IDLE, OP_SET, OP_RD, OP_CAP
`ifdef EFUSE_PGM_EN
        , OP_PGM
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       addr_q;
    logic             rd_q;
    logic             pgm_q;
    logic             st_rd;
    logic             st_wr;
    logic             op_done;
    logic             spi_en;
    logic             accept;

    // Program requests are only legal when the program path exists.
`ifdef EFUSE_PGM_EN
    assign accept = (state == IDLE) && op_req && efuse_done && cfg_en;
`else
    assign accept = (state == IDLE) && op_req && efuse_done && cfg_en && !efuse_mode;
`endif

    assign bus.fuse_addr = addr_q;
    assign bus.fuse_rd   = rd_q;
`ifdef EFUSE_PGM_EN
    assign bus.fuse_pgm  = pgm_q;
`else
    assign bus.fuse_pgm  = 1'b0;
`endif
    assign efuse_status  = {4'b0, spi_en, st_wr, st_rd, op_done};

    // addr_q doubles as the auto-load bit index n; st_wr also remembers the latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LD_SET;
            cnt        <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            pgm_q      <= 1'b0;
            efuse_data <= '0;
            efuse_done <= 1'b0;
            st_rd      <= 1'b0;
            st_wr      <= 1'b0;
            op_done    <= 1'b0;
            spi_en     <= 1'b0;
            op_busy    <= 1'b1;
        end else begin
            spi_en <= efuse_done & cfg_en;
            case (state)
                LD_SET: begin
                    rd_q  <= 1'b1;
                    cnt   <= '0;
                    state <= LD_RD;
                end
                LD_RD: begin
                    if (cnt == RD_LAST) begin
                        rd_q  <= 1'b0;
                        state <= LD_CAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LD_CAP: begin
                    efuse_data[addr_q] <= bus.fuse_q;
                    if (addr_q == 7'd127) begin
                        efuse_done <= 1'b1;
                        op_busy    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        addr_q <= addr_q + 7'd1;
                        state  <= LD_SET;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        addr_q  <= efuse_bit_addr;
                        op_done <= 1'b0;
                        st_rd   <= ~efuse_mode;
                        st_wr   <= efuse_mode;
                        op_busy <= 1'b1;
                        state   <= OP_SET;
                    end
                end
                OP_SET: begin
                    cnt <= '0;
`ifdef EFUSE_PGM_EN
                    // An already-blown bit needs no pulse, only the verifying read.
                    if (st_wr && !efuse_data[addr_q]) begin
                        pgm_q <= 1'b1;
                        state <= OP_PGM;
                    end else begin
                        rd_q  <= 1'b1;
                        state <= OP_RD;
                    end
`else
                    rd_q  <= 1'b1;
                    state <= OP_RD;
`endif
                end
`ifdef EFUSE_PGM_EN
                OP_PGM: begin
                    if (cnt == PGM_LAST) begin
                        pgm_q <= 1'b0;
                        rd_q  <= 1'b1;
                        cnt   <= '0;
                        state <= OP_RD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                OP_RD: begin
                    if (cnt == RD_LAST) begin
                        rd_q  <= 1'b0;
                        state <= OP_CAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OP_CAP: begin
                    efuse_data[addr_q] <= bus.fuse_q;
                    op_done <= 1'b1;
                    st_rd   <= 1'b0;
                    st_wr   <= 1'b0;
                    op_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= LD_SET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_ctrl.sv
// Directed bench for efuse_ctrl: auto-load timing, read op, dropped requests and the program path.
module tb_efuse_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_en = 1'b0;
    logic         efuse_mode = 1'b0;
    logic [6:0]   efuse_bit_addr = 7'd0;
    logic         op_req = 1'b0;
    logic [127:0] efuse_data;
    logic         efuse_done;
    logic [7:0]   efuse_status;
    logic         op_busy;
    logic [127:0] fuse_mem;

    int checks = 0;
    int errors = 0;
    int both_hi = 0;
    int pgm_hi = 0;

    localparam logic [127:0] LOAD_IMG = (128'd1 << 127) | 128'd8;

    efuse_ctrl_if bus ();

    assign bus.fuse_q = fuse_mem[bus.fuse_addr];

    efuse_ctrl #(.RD_CYC(4), .PGM_CYC(200)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .cfg_en         (cfg_en),
        .efuse_mode     (efuse_mode),
        .efuse_bit_addr (efuse_bit_addr),
        .op_req         (op_req),
        .efuse_data     (efuse_data),
        .efuse_done     (efuse_done),
        .efuse_status   (efuse_status),
        .op_busy        (op_busy)
    );

    always #5 clk = ~clk;

    // Fuse macro behaviour: a program strobe blows the addressed bit.
    always @(posedge clk) begin
        if (bus.fuse_pgm) fuse_mem[bus.fuse_addr] <= 1'b1;
    end

    always @(negedge clk) begin
        if (bus.fuse_rd && bus.fuse_pgm) both_hi++;
        if (bus.fuse_pgm) pgm_hi++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic [6:0] addr);
        efuse_mode     = mode;
        efuse_bit_addr = addr;
        op_req         = 1'b1;
        @(posedge clk);
        #1;
        op_req = 1'b0;
    endtask

    // Called right after the accepting edge; counts edges until efuse_op_done.
    task automatic waitDone(input logic [6:0] addr, output int cyc, output int rdst_n,
                            output int pgm_n, output int addr_bad);
        cyc = 0;
        rdst_n = 0;
        pgm_n = 0;
        addr_bad = 0;
        while (!efuse_status[0] && cyc < 2000) begin
            if (efuse_status[1]) rdst_n++;
            if (bus.fuse_pgm) pgm_n++;
            if (bus.fuse_addr != addr) addr_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int done_cyc;
        int ld_rd_n;
        logic done767;
        int cyc, rdst_n, pgm_n, addr_bad;

        fuse_mem = LOAD_IMG;
        done_cyc = 0;
        ld_rd_n = 0;
        done767 = 1'b1;

        tick(3);
        checkOutput("rst_data", efuse_data, 128'd0);
        checkOutput("rst_done", efuse_done, 0);
        checkOutput("rst_status", efuse_status, 0);
        checkOutput("rst_addr", bus.fuse_addr, 0);
        checkOutput("rst_fuse_rd", bus.fuse_rd, 0);
        checkOutput("rst_fuse_pgm", bus.fuse_pgm, 0);
        checkOutput("rst_busy", op_busy, 1);
        rst = 1'b0;

        for (int c = 1; c <= 800 && done_cyc == 0; c++) begin
            op_req = (c == 100);
            cfg_en = (c == 100);
            efuse_mode = 1'b0;
            efuse_bit_addr = 7'd3;
            @(posedge clk);
            #1;
            if (bus.fuse_rd) ld_rd_n++;
            if (c == 100) begin
                checkOutput("drop_load_status", efuse_status, 0);
                checkOutput("drop_load_busy", op_busy, 1);
            end
            if (c == 767) done767 = efuse_done;
            if (efuse_done) done_cyc = c;
        end
        op_req = 1'b0;
        cfg_en = 1'b0;
        checkOutput("load_done_cycle", done_cyc, 768);
        checkOutput("load_done_early", done767, 0);
        checkOutput("load_rd_cycles", ld_rd_n, 512);
        checkOutput("load_data", efuse_data, LOAD_IMG);
        checkOutput("load_status", efuse_status, 0);
        checkOutput("idle_busy", op_busy, 0);

        cfg_en = 1'b1;
        tick(1);
        checkOutput("spi_en_status", efuse_status, 8'h08);

        cfg_en = 1'b0;
        tick(1);
        applyStimulus(1'b0, 7'd5);
        checkOutput("drop_cfg_busy", op_busy, 0);
        tick(3);
        checkOutput("drop_cfg_status", efuse_status, 0);
        checkOutput("drop_cfg_rd", bus.fuse_rd, 0);
        checkOutput("drop_cfg_data", efuse_data, LOAD_IMG);

        fuse_mem[5] = 1'b1;
        cfg_en = 1'b1;
        tick(1);
        applyStimulus(1'b0, 7'd5);
        checkOutput("read_accept_status", efuse_status, 8'h0A);
        fork
            waitDone(7'd5, cyc, rdst_n, pgm_n, addr_bad);
            begin
                op_req = 1'b1;
                efuse_bit_addr = 7'd7;
                @(posedge clk);
                #2;
                op_req = 1'b0;
                cfg_en = 1'b0;
            end
        join
        checkOutput("read_cycles", cyc, 6);
        checkOutput("read_rd_status_cycles", rdst_n, 6);
        checkOutput("read_addr_stable", addr_bad, 0);
        checkOutput("read_done_status", efuse_status, 8'h01);
        checkOutput("read_data", efuse_data, LOAD_IMG | 128'd32);
        tick(2);
        checkOutput("read_busy_drop", op_busy, 0);
        checkOutput("read_busy_drop_addr", bus.fuse_addr, 5);

`ifdef EFUSE_PGM_EN
        cfg_en = 1'b1;
        tick(1);
        applyStimulus(1'b1, 7'd10);
        checkOutput("pgm_accept_status", efuse_status, 8'h0C);
        waitDone(7'd10, cyc, rdst_n, pgm_n, addr_bad);
        checkOutput("pgm_cycles", cyc, 206);
        checkOutput("pgm_pulse", pgm_n, 200);
        checkOutput("pgm_addr_stable", addr_bad, 0);
        checkOutput("pgm_done_status", efuse_status, 8'h09);
        checkOutput("pgm_data", efuse_data, LOAD_IMG | 128'd32 | (128'd1 << 10));

        applyStimulus(1'b1, 7'd3);
        waitDone(7'd3, cyc, rdst_n, pgm_n, addr_bad);
        checkOutput("skip_cycles", cyc, 6);
        checkOutput("skip_pulse", pgm_n, 0);
        checkOutput("skip_status", efuse_status, 8'h09);

        applyStimulus(1'b1, 7'd20);
        pgm_n = 0;
        for (int c = 0; c < 100 && pgm_n < 50; c++) begin
            if (bus.fuse_pgm) pgm_n++;
            if (pgm_n < 50) tick(1);
        end
        checkOutput("rst_pgm_reached", pgm_n, 50);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_pgm_drop", bus.fuse_pgm, 0);
        checkOutput("rst_pgm_busy", op_busy, 1);
        checkOutput("rst_pgm_done", efuse_done, 0);
        rst = 1'b0;
        tick(1);
        checkOutput("reload_addr", bus.fuse_addr, 0);
        checkOutput("reload_rd", bus.fuse_rd, 1);
`else
        cfg_en = 1'b1;
        tick(1);
        applyStimulus(1'b1, 7'd10);
        checkOutput("nopgm_accept_busy", op_busy, 0);
        tick(5);
        checkOutput("nopgm_status", efuse_status, 8'h09);
        checkOutput("nopgm_busy", op_busy, 0);
        checkOutput("nopgm_data", efuse_data, LOAD_IMG | 128'd32);
        checkOutput("nopgm_pulses", pgm_hi, 0);
`endif
        checkOutput("rd_pgm_overlap", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/efuse_ctrl.md
EFUSE_CTRL -- requirements
Module: efuse_ctrl

Interface
REQ-001 SHALL have parameter RD_CYC, default 4: cycles fuse_rd is held high per bit read, range 1..15.
REQ-002 SHALL have parameter PGM_CYC, default 200: cycles fuse_pgm is held high per bit program, range 1..1023.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_en  input  1  config-mode enable from the mode register.
REQ-006 SHALL have port efuse_mode  input  1  1 = program, 0 = read.
REQ-007 SHALL have port efuse_bit_addr  input  7  target fuse bit, 0..127.
REQ-008 SHALL have port op_req  input  1  single-cycle operation request.
REQ-009 SHALL have port fuse_q  input  1  fuse macro read data, valid in the capture cycle.
REQ-010 SHALL have port fuse_addr  output  7  fuse macro bit address.
REQ-011 SHALL have port fuse_rd  output  1  fuse macro read strobe.
REQ-012 SHALL have port fuse_pgm  output  1  fuse macro program strobe.
REQ-013 SHALL have port efuse_data  output  128  shadow copy of the fuse array.
REQ-014 SHALL have port efuse_done  output  1  power-up load complete.
REQ-015 SHALL have port efuse_status  output  8  status bits {4'b0, spi_read_efuse_en, efuse_wr, efuse_rd, efuse_op_done}.
REQ-016 SHALL have port op_busy  output  1  controller is not idle.

Function
REQ-017 SHALL implement FSM states LD_SET, LD_RD, LD_CAP, IDLE, OP_SET, OP_PGM, OP_RD, OP_CAP.
REQ-018 Auto-load SHALL run after reset: LD_SET (1 cycle, fuse_addr=n) -> LD_RD (fuse_rd=1 for RD_CYC cycles) -> LD_CAP (efuse_data[n]<=fuse_q); n increments 0..127, then IDLE.
REQ-019 Each bit load SHALL take RD_CYC+2 cycles; efuse_done SHALL rise on entry to IDLE, 128*(RD_CYC+2) cycles after rst falls, and SHALL stay high until rst.
REQ-020 op_req SHALL be accepted only in IDLE with efuse_done=1 and cfg_en=1; otherwise it is dropped with no state or status change.
REQ-021 On accept, the controller SHALL latch efuse_bit_addr and efuse_mode, clear efuse_op_done, set efuse_rd (mode 0) or efuse_wr (mode 1), and enter OP_SET.
REQ-022 Read: OP_SET -> OP_RD (RD_CYC cycles) -> OP_CAP. OP_CAP SHALL write efuse_data[addr]<=fuse_q, set efuse_op_done, clear efuse_rd/efuse_wr, and return to IDLE.
REQ-023 Program: OP_SET -> OP_PGM (fuse_pgm=1 for PGM_CYC cycles) -> OP_RD -> OP_CAP, so the shadow bit reflects the verified read-back.
REQ-024 Program of an address whose efuse_data bit is already 1 SHALL skip OP_PGM and go directly to OP_RD.
REQ-025 fuse_rd and fuse_pgm SHALL never be high in the same cycle; both SHALL be 0 in IDLE; fuse_addr SHALL be stable from OP_SET through OP_CAP.
REQ-026 op_busy SHALL be 1 in every state except IDLE; op_req while busy SHALL be ignored.
REQ-027 spi_read_efuse_en SHALL equal efuse_done AND cfg_en, registered.
REQ-028 Dropping cfg_en mid-operation SHALL NOT abort the operation.

Reset
REQ-029 rst SHALL force state LD_SET, n=0, efuse_data=0, efuse_done=0, efuse_status=0, fuse_addr=0, fuse_rd=0, fuse_pgm=0, op_busy=1.
REQ-030 rst asserted mid-program SHALL drop fuse_pgm on the next edge and restart the auto-load.

Configuration
REQ-031 Macro EFUSE_PGM_EN defined: programming is supported as specified above.
REQ-032 Macro EFUSE_PGM_EN undefined: OP_PGM is not built, fuse_pgm is tied to 0, and an op_req with efuse_mode=1 is dropped as in REQ-020 (efuse_wr is never set).

Verification
REQ-033 Auto-load: fuse model with bits 3 and 127 = 1, RD_CYC=4 -> efuse_done rises at cycle 768 after rst falls; efuse_data = 2^127 + 8.
REQ-034 Read: after load, cfg_en=1, op_req with mode=0, addr=5, fuse_q=1 -> efuse_rd=1 for 6 cycles, then efuse_op_done=1 and efuse_data[5]=1.
REQ-035 Program: mode=1, addr=10, bit=0 -> fuse_pgm high for exactly 200 cycles with fuse_addr=10, then a read-back; efuse_op_done=1 and efuse_wr=0 at completion.
REQ-036 Program of an already-set bit: addr=3 -> no fuse_pgm pulse; op_done is reached after RD_CYC+2 cycles.
REQ-037 Drops: op_req during load, with cfg_en=0, or while busy -> no status change and no fuse strobes; rst at PGM cycle 50 -> fuse_pgm=0 on the next edge and the load restarts at n=0.
REQ-038 With EFUSE_PGM_EN undefined: op_req with mode=1 -> fuse_pgm stays 0, efuse_status unchanged, op_busy stays 0.
